// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_scheduler
// Description : Issue controller for the two-slot instruction cache feeding
//               the paired ALU/register-file datapaths. Accepts instruction
//               pairs, detects intra-pair RAW/WAW hazards, and issues a pair
//               dual in one cycle or split over two cycles on datapath 1.
//               Optional performance counters: define SCHED_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr0,
    input  logic [31:0]      in_instr1,
    output logic             dp1_en,
    output logic [31:0]      dp1_instr,
    output logic             dp2_en,
    output logic [31:0]      dp2_instr,
    output logic             dp1_wr,
    output logic             dp2_wr,
    output logic             split,
    output logic [CNT_W-1:0] dual_cnt,
    output logic [CNT_W-1:0] split_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_PAIR   = 2'd1,
        S_SECOND = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_i0_q;
    logic [31:0] r_i1_q;
    logic        w_hazard;
    logic        w_accept;

    // Instruction writes a non-zero rd (a zero word has opcode 0 and never matches)
    function automatic logic f_writes_rd(input logic [31:0] ins);
        logic w_op;
        case (ins[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: w_op = 1'b1;
            default:                            w_op = 1'b0;
        endcase
        return w_op && (ins[11:7] != 5'd0);
    endfunction

    // Every non-bubble instruction reads rs1 except LUI, AUIPC and JAL
    function automatic logic f_reads_rs1(input logic [31:0] ins);
        logic w_no;
        case (ins[6:0])
            7'b0110111, 7'b0010111, 7'b1101111: w_no = 1'b1;
            default:                            w_no = 1'b0;
        endcase
        return (ins != 32'd0) && !w_no;
    endfunction

    // Only register-register ALU ops, stores and branches read rs2
    function automatic logic f_reads_rs2(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Intra-pair hazard: younger instruction reads or rewrites the older rd
    always_comb begin
        w_hazard = (r_state == S_PAIR) && f_writes_rd(r_i0_q) &&
                   ((f_reads_rs1(r_i1_q) && (r_i1_q[19:15] == r_i0_q[11:7])) ||
                    (f_reads_rs2(r_i1_q) && (r_i1_q[24:20] == r_i0_q[11:7])) ||
                    (f_writes_rd(r_i1_q) && (r_i1_q[11:7]  == r_i0_q[11:7])));
    end

    // Next-state, handshake and issue outputs
    always_comb begin
        w_state_nxt = r_state;
        dp1_en      = 1'b0;
        dp1_instr   = 32'd0;
        dp2_en      = 1'b0;
        dp2_instr   = 32'd0;
        in_ready    = en && ((r_state == S_EMPTY) || (r_state == S_SECOND) ||
                             ((r_state == S_PAIR) && !w_hazard));
        w_accept    = in_valid && in_ready;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) w_state_nxt = S_PAIR;
            end
            S_PAIR: begin
                dp1_en    = en && (r_i0_q != 32'd0);
                dp1_instr = r_i0_q;
                if (w_hazard) begin
                    if (en) w_state_nxt = S_SECOND;
                end else begin
                    dp2_en    = en && (r_i1_q != 32'd0);
                    dp2_instr = r_i1_q;
                    if (en) w_state_nxt = w_accept ? S_PAIR : S_EMPTY;
                end
            end
            S_SECOND: begin
                dp1_en    = en && (r_i1_q != 32'd0);
                dp1_instr = r_i1_q;
                if (en) w_state_nxt = w_accept ? S_PAIR : S_EMPTY;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        dp1_wr = dp1_en && f_writes_rd(dp1_instr);
        dp2_wr = dp2_en && f_writes_rd(dp2_instr);
        split  = w_hazard;
    end

    // State and held-pair registers; everything holds while en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_i0_q  <= 32'd0;
            r_i1_q  <= 32'd0;
        end else if (en) begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_i0_q <= in_instr0;
                r_i1_q <= in_instr1;
            end
        end
    end

`ifdef SCHED_PERF_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_dual_cnt;
    logic [CNT_W-1:0] r_split_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating performance counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dual_cnt  <= '0;
            r_split_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (en) begin
            if ((r_state == S_PAIR) && !w_hazard && (r_dual_cnt != c_CNT_MAX))
                r_dual_cnt <= r_dual_cnt + 1'b1;
            if (w_hazard && (r_split_cnt != c_CNT_MAX))
                r_split_cnt <= r_split_cnt + 1'b1;
            if (in_valid && !in_ready && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign dual_cnt  = r_dual_cnt;
    assign split_cnt = r_split_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign dual_cnt  = '0;
    assign split_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_issue_scheduler
// Description : Scoreboard bench for dual_issue_scheduler. Stimulus queues the
//               expected issue vector for each pair; a negedge monitor pops
//               and compares whenever a datapath slot is enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_issue_scheduler;

`ifdef SCHED_PERF_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    localparam logic [31:0] c_ADDI_X1_5 = 32'h00500093;
    localparam logic [31:0] c_ADDI_X2_7 = 32'h00700113;
    localparam logic [31:0] c_ADDI_X1_7 = 32'h00700093;
    localparam logic [31:0] c_ADD_X3_X1 = 32'h001081B3;
    localparam logic [31:0] c_ADDI_X0_1 = 32'h00100013;
    localparam logic [31:0] c_ADD_X3_X0 = 32'h000001B3;
    localparam logic [31:0] c_SW_X1_X2  = 32'h00112023;
    localparam logic [31:0] c_LUI_X5_8  = 32'h000082B7;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr0;
    logic [31:0] in_instr1;
    logic        dp1_en;
    logic [31:0] dp1_instr;
    logic        dp2_en;
    logic [31:0] dp2_instr;
    logic        dp1_wr;
    logic        dp2_wr;
    logic        split;
    logic [15:0] dual_cnt;
    logic [15:0] split_cnt;
    logic [15:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [67:0] exp_q[$];

    dual_issue_scheduler #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr0(in_instr0), .in_instr1(in_instr1),
        .dp1_en(dp1_en), .dp1_instr(dp1_instr), .dp2_en(dp2_en), .dp2_instr(dp2_instr),
        .dp1_wr(dp1_wr), .dp2_wr(dp2_wr), .split(split),
        .dual_cnt(dual_cnt), .split_cnt(split_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic e1, input logic [31:0] i1, input logic e2,
                        input logic [31:0] i2, input logic w1, input logic w2);
        exp_q.push_back({e1, i1, e2, i2, w1, w2});
    endtask

    task automatic chk_cnt(input string tag, input int d, input int s, input int st);
        chk({tag, " dual_cnt"},  {16'd0, dual_cnt},  c_PERF ? d  : 0);
        chk({tag, " split_cnt"}, {16'd0, split_cnt}, c_PERF ? s  : 0);
        chk({tag, " stall_cnt"}, {16'd0, stall_cnt}, c_PERF ? st : 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " dp1_en"},    {31'd0, dp1_en}, 0);
        chk({tag, " dp2_en"},    {31'd0, dp2_en}, 0);
        chk({tag, " dp1_instr"}, dp1_instr, 0);
        chk({tag, " dp2_instr"}, dp2_instr, 0);
        chk({tag, " dp1_wr"},    {31'd0, dp1_wr}, 0);
        chk({tag, " dp2_wr"},    {31'd0, dp2_wr}, 0);
        chk({tag, " split"},     {31'd0, split}, 0);
    endtask

    // Monitor: every enabled issue slot must match the next queued expectation
    always @(negedge clk) begin
        if (dp1_en === 1'b1 || dp2_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: got %h expected none",
                         {dp1_en, dp1_instr, dp2_en, dp2_instr, dp1_wr, dp2_wr});
            end else begin
                logic [67:0] e;
                e = exp_q.pop_front();
                if ({dp1_en, dp1_instr, dp2_en, dp2_instr, dp1_wr, dp2_wr} !== e) begin
                    n_fail++;
                    $display("FAIL issue_vector: got %h expected %h",
                             {dp1_en, dp1_instr, dp2_en, dp2_instr, dp1_wr, dp2_wr}, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_instr0 = '0; in_instr1 = '0;
        tick(); tick();
        chk_idle("reset");
        chk("reset in_ready", {31'd0, in_ready}, 1);
        chk_cnt("reset", 0, 0, 0);
        en = 1'b0; #1;
        chk("reset in_ready en0", {31'd0, in_ready}, 0);
        en = 1'b1;
        rst = 1'b0;
        tick();

        // Independent pair: dual issue
        in_valid = 1'b1; in_instr0 = c_ADDI_X1_5; in_instr1 = c_ADDI_X2_7;
        push(1, c_ADDI_X1_5, 1, c_ADDI_X2_7, 1, 1);
        tick();
        chk("indep in_ready", {31'd0, in_ready}, 1);
        chk("indep split", {31'd0, split}, 0);
        in_valid = 1'b0;
        tick();
        chk_cnt("indep", 1, 0, 0);

        // RAW pair, with the next (x0-destination) pair held on the input
        in_valid = 1'b1; in_instr0 = c_ADDI_X1_5; in_instr1 = c_ADD_X3_X1;
        push(1, c_ADDI_X1_5, 0, 0, 1, 0);
        push(1, c_ADD_X3_X1, 0, 0, 1, 0);
        tick();
        chk("raw split", {31'd0, split}, 1);
        chk("raw in_ready", {31'd0, in_ready}, 0);
        chk("raw dp2_instr", dp2_instr, 0);
        in_instr0 = c_ADDI_X0_1; in_instr1 = c_ADD_X3_X0;
        tick();
        chk("second in_ready", {31'd0, in_ready}, 1);
        chk("second dp1_instr", dp1_instr, c_ADD_X3_X1);
        chk_cnt("raw", 1, 1, 1);
        push(1, c_ADDI_X0_1, 1, c_ADD_X3_X0, 0, 1);
        tick();
        chk("x0 split", {31'd0, split}, 0);
        in_valid = 1'b0;
        tick();
        chk_cnt("x0", 2, 1, 1);

        // Bubble in slot 0 with a store in slot 1
        in_valid = 1'b1; in_instr0 = 32'd0; in_instr1 = c_SW_X1_X2;
        push(0, 0, 1, c_SW_X1_X2, 0, 0);
        tick();
        in_valid = 1'b0;
        tick();
        chk_cnt("bubble", 3, 1, 0 + 1);

        // LUI does not read rs1, so a matching rs1 field is not a hazard
        in_valid = 1'b1; in_instr0 = c_ADDI_X1_5; in_instr1 = c_LUI_X5_8;
        push(1, c_ADDI_X1_5, 1, c_LUI_X5_8, 1, 1);
        tick();
        chk("lui split", {31'd0, split}, 0);
        in_valid = 1'b0;
        tick();

        // en gating: three idle cycles in PAIR, then issue proceeds unchanged
        in_valid = 1'b1; in_instr0 = c_ADDI_X2_7; in_instr1 = c_ADD_X3_X1;
        push(1, c_ADDI_X2_7, 1, c_ADD_X3_X1, 1, 1);
        tick();
        en = 1'b0; in_valid = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("gate dp1_en", {31'd0, dp1_en}, 0);
            chk("gate dp2_wr", {31'd0, dp2_wr}, 0);
            chk("gate in_ready", {31'd0, in_ready}, 0);
            chk("gate dp1_instr", dp1_instr, c_ADDI_X2_7);
            chk("gate dp2_instr", dp2_instr, c_ADD_X3_X1);
            chk_cnt("gate", 4, 1, 1);
            tick();
        end
        en = 1'b1;
        tick();
        chk_cnt("gate_done", 5, 1, 1);

        // WAW pair, then reset while in SECOND
        in_valid = 1'b1; in_instr0 = c_ADDI_X1_5; in_instr1 = c_ADDI_X1_7;
        push(1, c_ADDI_X1_5, 0, 0, 1, 0);
        push(1, c_ADDI_X1_7, 0, 0, 1, 0);
        tick();
        chk("waw split", {31'd0, split}, 1);
        in_valid = 1'b0;
        tick();
        chk("waw second dp1_instr", dp1_instr, c_ADDI_X1_7);
        chk_cnt("waw", 5, 2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk_idle("midsplit_rst");
        chk_cnt("midsplit_rst", 0, 0, 0);
        tick();
        chk_idle("after_rst");

        chk("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
